vppm_symbol_demod: RTL and testbench

Downstream consumer of the ADC control stage. Takes each 12-bit photodiode sample when the ADC's data-ready level rises, slices it against a programmable threshold with hysteresis, and locks to the symbol boundary after an idle gap. It then decides each VPPM symbol by comparing pulse energy in the two half-periods and assembles start + 8 data symbols into one byte. Output feeds the framing/UART layer of the VPPM receiver.

---
 rtl/vppm_symbol_demod.sv | 209 ++++++++++++++++++++
 tb/tb_vppm_symbol_demod.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vppm_symbol_demod.sv
// ---------------------------------------------------------------------------
// vppm_symbol_demod
//
// Slices 12-bit photodiode samples against a threshold with hysteresis, locks
// to the VPPM symbol boundary after an idle gap, decides each symbol by
// comparing pulse energy in its two half-periods and assembles a start symbol
// plus 8 data symbols (LSB first) into one byte.
//
// Parameters:
//   SPS   ADC samples per VPPM symbol (even, 4..64)
//   HYST  hysteresis half-width in ADC LSBs
//
// Ports:
//   iCLK     clock shared with the ADC controller (rising edge)
//   iRST     asynchronous active-low reset
//   iSAMPLE  12-bit ADC sample, stable while iDR is high
//   iDR      ADC data-ready level; each 0->1 transition carries one sample
//   iTHRESH  12-bit slicing threshold (quasi-static)
//   oDATA    decoded byte, held until the next oVALID
//   oVALID   one-cycle strobe qualifying oDATA
//   oFERR    one-cycle frame-error strobe
//   oSYNC    high while a frame is being collected
//   oSLICE   current sliced level (debug)
//
// Output handshake: oVALID/oFERR are one-cycle strobes with no back-pressure.
// The consumer must take oDATA on the cycle oVALID is high; oFERR may arrive
// alone (start-symbol error, byte dropped) or together with oVALID (a data
// symbol had equal halves, byte delivered with that bit forced to 0).
// oSYNC together with oSLICE exposes the FSM progress for debug.
// ---------------------------------------------------------------------------
module vppm_symbol_demod #(
  parameter int SPS  = 16,
  parameter int HYST = 64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iSAMPLE,
  input  logic        iDR,
  input  logic [11:0] iTHRESH,
  output logic [7:0]  oDATA,
  output logic        oVALID,
  output logic        oFERR,
  output logic        oSYNC,
  output logic        oSLICE
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] HALF     = CW'(SPS / 2);
  localparam logic [CW-1:0] HALF_M1  = CW'(SPS / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(SPS - 1);
  localparam logic [CW-1:0] SCNT_ONE = CW'(1);
  localparam logic [CW:0]   CNT_ONE  = (CW + 1)'(1);
  localparam logic [12:0]   HYST13   = 13'(HYST);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ARMED  = 2'd1,
    SYMBOL = 2'd2
  } stateT;

  stateT         state;
  logic          drQ;
  logic          slice;
  logic          sStb;
  logic [CW-1:0] lowRun;
  logic [CW-1:0] sCnt;
  logic [CW:0]   c0;
  logic [CW:0]   c1;
  logic [3:0]    symIdx;
  logic [7:0]    shReg;
  logic          tieErr;

  // Hysteresis window, 13-bit sums clamped into the 12-bit sample range.
  logic [12:0] hiSum;
  logic [12:0] loDiff;
  logic [11:0] hiThr;
  logic [11:0] loThr;
  logic        sampleAcc;

  assign hiSum     = {1'b0, iTHRESH} + HYST13;
  assign loDiff    = {1'b0, iTHRESH} - HYST13;
  assign hiThr     = hiSum[12] ? 12'hFFF : hiSum[11:0];
  assign loThr     = loDiff[12] ? 12'h000 : loDiff[11:0];
  assign sampleAcc = iDR & ~drQ;

  // drQ resets to 1 so a data-ready level already high at reset release is
  // not mistaken for a fresh sample.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      drQ   <= 1'b1;
      slice <= 1'b0;
      sStb  <= 1'b0;
    end else begin
      drQ  <= iDR;
      sStb <= sampleAcc;
      if (sampleAcc) begin
        if (iSAMPLE >= hiThr)
          slice <= 1'b1;
        else if (iSAMPLE < loThr)
          slice <= 1'b0;
      end
    end
  end

  // Half-period energy including the current sample, and the symbol decision
  // taken from it on the last sample of the symbol.
  logic [CW:0] c0Next;
  logic [CW:0] c1Next;
  logic        symBit;
  logic        symTie;
  logic [7:0]  shNext;

  always_comb begin
    c0Next = c0;
    c1Next = c1;
    if (slice) begin
      if (sCnt < HALF)
        c0Next = c0 + CNT_ONE;
      else
        c1Next = c1 + CNT_ONE;
    end
    symBit = (c1Next > c0Next);
    symTie = (c1Next == c0Next);
    shNext = {symBit, shReg[7:1]};
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state  <= HUNT;
      lowRun <= '0;
      sCnt   <= '0;
      c0     <= '0;
      c1     <= '0;
      symIdx <= '0;
      shReg  <= '0;
      tieErr <= 1'b0;
      oDATA  <= '0;
      oVALID <= 1'b0;
      oFERR  <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      oFERR  <= 1'b0;
      if (sStb) begin
        case (state)
          HUNT: begin
            if (slice) begin
              lowRun <= '0;
            end else begin
              if (lowRun != HALF)
                lowRun <= lowRun + SCNT_ONE;
              if (lowRun >= HALF_M1)
                state <= ARMED;
            end
          end
          ARMED: begin
            // First high sample after the idle gap is sample 0 of the start.
            if (slice) begin
              state  <= SYMBOL;
              sCnt   <= SCNT_ONE;
              c0     <= CNT_ONE;
              c1     <= '0;
              symIdx <= '0;
              tieErr <= 1'b0;
            end
          end
          SYMBOL: begin
            if (sCnt == LAST) begin
              sCnt <= '0;
              c0   <= '0;
              c1   <= '0;
              if (symIdx == 4'd0) begin
                // Start symbol must carry its pulse in the first half.
                if (symBit || symTie) begin
                  oFERR  <= 1'b1;
                  state  <= HUNT;
                  lowRun <= '0;
                end else begin
                  symIdx <= 4'd1;
                end
              end else begin
                shReg <= shNext;
                if (symIdx == 4'd8) begin
                  oDATA  <= shNext;
                  oVALID <= 1'b1;
                  oFERR  <= tieErr | symTie;
                  tieErr <= 1'b0;
                  state  <= HUNT;
                  lowRun <= '0;
                end else begin
                  tieErr <= tieErr | symTie;
                  symIdx <= symIdx + 4'd1;
                end
              end
            end else begin
              sCnt <= sCnt + SCNT_ONE;
              c0   <= c0Next;
              c1   <= c1Next;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign oSYNC  = (state == SYMBOL);
  assign oSLICE = slice;

endmodule

// File: tb/tb_vppm_symbol_demod.sv
// ---------------------------------------------------------------------------
// tb_vppm_symbol_demod
//
// Drives VPPM frames sample by sample through the data-ready handshake and
// checks decoded bytes, error strobes and their timing against an expected
// queue, plus slicer hysteresis and reset behaviour.
// ---------------------------------------------------------------------------
module tb_vppm_symbol_demod;

  localparam int SPS  = 16;
  localparam int HYST = 64;
  localparam logic [11:0] HI_LVL = 12'd3000;
  localparam logic [11:0] LO_LVL = 12'd500;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [11:0] sample;
  logic        dr;
  logic [11:0] thresh;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_ferr;
  logic        o_sync;
  logic        o_slice;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  vppm_symbol_demod #(.SPS(SPS), .HYST(HYST)) dut (
    .iCLK    (clk),
    .iRST    (rst_n),
    .iSAMPLE (sample),
    .iDR     (dr),
    .iTHRESH (thresh),
    .oDATA   (o_data),
    .oVALID  (o_valid),
    .oFERR   (o_ferr),
    .oSYNC   (o_sync),
    .oSLICE  (o_slice)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {cycle seen at negedge, valid, ferr, data}
  logic [41:0] exp_q[$];
  logic [7:0]  last_byte = 8'h00;

  always @(negedge clk) begin
    if (rst_n && (o_valid || o_ferr)) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", {62'd0, o_valid, o_ferr}, 64'd0);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("out_valid", {63'd0, o_valid}, {63'd0, e[9]});
        check("out_ferr",  {63'd0, o_ferr},  {63'd0, e[8]});
        check("out_data",  {56'd0, o_data},  {56'd0, e[7:0]});
        check("out_cycle", {32'd0, cyc},     {32'd0, e[41:10]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One ADC sample: data-ready high for one cycle, then low for three.
  task automatic send_sample(input logic [11:0] val, input logic push_it,
                             input logic e_valid, input logic e_ferr, input logic [7:0] e_data);
    @(negedge clk);
    sample = val;
    dr = 1'b1;
    // Accepting edge is the next posedge; strobes are visible after the one after.
    if (push_it) exp_q.push_back({cyc + 32'd2, e_valid, e_ferr, e_data});
    @(negedge clk);
    dr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [11:0] sym_level(input logic b, input int w, input logic tie, input int i);
    logic high;
    if (tie)
      high = (i < w / 2) || (i >= SPS / 2 && i < SPS / 2 + w / 2);
    else if (!b)
      high = (i < w);
    else
      high = (i >= SPS - w);
    return high ? HI_LVL : LO_LVL;
  endfunction

  // push_at: sample index at which an expected strobe is queued (-1: none).
  task automatic send_symbol(input logic b, input int w, input logic tie, input int push_at,
                             input logic e_valid, input logic e_ferr, input logic [7:0] e_data);
    for (int i = 0; i < SPS; i++)
      send_sample(sym_level(b, w, tie, i), (i == push_at), e_valid, e_ferr, e_data);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_sample(LO_LVL, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Start + 8 data symbols; tie_bit >= 0 gives that data symbol equal halves.
  task automatic send_frame(input logic [7:0] b, input int w, input int tie_bit);
    logic [7:0] res;
    res = b;
    if (tie_bit >= 0) res[tie_bit] = 1'b0;
    send_symbol(1'b0, w, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      send_symbol(b[k], w, (k == tie_bit), (k == 7) ? SPS - 1 : -1,
                  1'b1, (tie_bit >= 0), res);
      if (k == 3) check("sync_mid_frame", {63'd0, o_sync}, 64'd1);
    end
    last_byte = res;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    dr     = 1'b0;
    sample = 12'd0;
    thresh = 12'd2048;
    repeat (3) @(negedge clk);
    check("rst_data",  {56'd0, o_data},  64'd0);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_ferr",  {63'd0, o_ferr},  64'd0);
    check("rst_sync",  {63'd0, o_sync},  64'd0);
    check("rst_slice", {63'd0, o_slice}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic byte, 50% duty
    send_idle(10);
    check("idle_sync", {63'd0, o_sync}, 64'd0);
    send_frame(8'hA5, 8, -1);
    send_idle(SPS);
    check("post_frame_sync", {63'd0, o_sync}, 64'd0);

    // Dimming: 25% then 12.5% duty
    send_frame(8'h3C, 4, -1);
    send_idle(SPS);
    send_frame(8'hFF, 2, -1);
    send_idle(SPS);

    // Start error: start pulse in the second half aligns the decoder mid-symbol;
    // the following bit-0 symbol fills the other half, giving an error.
    send_symbol(1'b1, 8, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    send_symbol(1'b0, 8, 1'b0, 7, 1'b0, 1'b1, last_byte);
    send_idle(SPS);
    send_frame(8'h5A, 8, -1);
    send_idle(SPS);

    // Tie on data bit 3, then back-to-back with exactly one idle symbol
    send_frame(8'hFF, 8, 3);
    send_idle(SPS);
    send_frame(8'h81, 8, -1);
    send_idle(SPS);

    // Random bytes and duties
    for (int r = 0; r < 3; r++) begin
      logic [7:0] rb;
      int rw;
      rb = 8'($urandom_range(0, 255));
      rw = $urandom_range(1, 8);
      send_frame(rb, rw, -1);
      send_idle(SPS);
    end

    // Hysteresis window 1984..2111 at threshold 2048
    send_idle(4);
    check("hyst_pre", {63'd0, o_slice}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      send_sample((i % 2 == 0) ? 12'd2000 : 12'd2100, 1'b0, 1'b0, 1'b0, 8'h00);
      check("hyst_hold_low", {63'd0, o_slice}, 64'd0);
    end
    send_sample(12'd2112, 1'b0, 1'b0, 1'b0, 8'h00);
    check("hyst_rise", {63'd0, o_slice}, 64'd1);
    send_sample(12'd1990, 1'b0, 1'b0, 1'b0, 8'h00);
    check("hyst_hold_high", {63'd0, o_slice}, 64'd1);
    check("hyst_sync", {63'd0, o_sync}, 64'd1);

    // Reset mid-frame with data-ready held high through release
    @(negedge clk);
    sample = HI_LVL;
    dr     = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    check("mid_rst_slice", {63'd0, o_slice}, 64'd0);
    check("mid_rst_sync",  {63'd0, o_sync},  64'd0);
    check("mid_rst_data",  {56'd0, o_data},  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rel_slice", {63'd0, o_slice}, 64'd0);
    check("rel_sync",  {63'd0, o_sync},  64'd0);
    check("rel_valid", {63'd0, o_valid}, 64'd0);
    check("rel_ferr",  {63'd0, o_ferr},  64'd0);
    last_byte = 8'h00;
    dr = 1'b0;
    send_sample(HI_LVL, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rel_new_sample", {63'd0, o_slice}, 64'd1);
    send_idle(SPS);
    send_frame(8'h33, 8, -1);
    send_idle(SPS);

    // ---------------- report ----------------
    repeat (10) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
